// File: rtl/data_memory_ctrl_pkg.sv
// ============================================================================
// Module : data_memory_ctrl_pkg
// Brief  : Shared FSM state encodings, op encoding and wait-state helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package data_memory_ctrl_pkg;

  localparam logic [1:0] c_IDLE        = 2'd0;
  localparam logic [1:0] c_ACCESS      = 2'd1;
  localparam logic [1:0] c_ACKNOWLEDGE = 2'd2;
  localparam logic [1:0] c_RELEASE     = 2'd3;

  localparam logic c_OP_WR = 1'b0;
  localparam logic c_OP_RD = 1'b1;

  localparam int c_DEFAULT_WAIT_STATES = 2;

  // Out-of-range wait-state requests clamp to what the counter can hold.
  function automatic int satLoad(input int waitStates, input int cntWidth);
    int maxCount;
    maxCount = (1 << cntWidth) - 1;
    if (waitStates > maxCount) return maxCount;
    if (waitStates < 0)        return 0;
    return waitStates;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory_ctrl_if.sv
// ============================================================================
// Module : data_memory_ctrl_if
// Brief  : Control-side request bus plus Data_Memory strobe/data bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface data_memory_ctrl_if #(
  parameter int DATAWIDTH_BUS = 32
);
  logic                     MemCtrl_RD_In;
  logic                     MemCtrl_WR_In;
  logic [DATAWIDTH_BUS-1:0] MemCtrl_Address_In;
  logic [DATAWIDTH_BUS-1:0] MemCtrl_Data_In;
  logic [DATAWIDTH_BUS-1:0] MemCtrl_Data_Out;
  logic                     MemCtrl_ACK_Out;
  logic                     MemCtrl_Busy_Out;
  logic                     MemCtrl_Error_Out;
  logic                     Mem_RD_Out;
  logic                     Mem_WR_Out;
  logic [DATAWIDTH_BUS-1:0] Mem_Address_Out;
  logic [DATAWIDTH_BUS-1:0] Mem_Data_Out;
  logic [DATAWIDTH_BUS-1:0] Mem_Data_In;

  // Master is the system side: sequencer/datapath plus the memory array.
  modport master (
    output MemCtrl_RD_In, MemCtrl_WR_In, MemCtrl_Address_In, MemCtrl_Data_In, Mem_Data_In,
    input  MemCtrl_Data_Out, MemCtrl_ACK_Out, MemCtrl_Busy_Out, MemCtrl_Error_Out,
    input  Mem_RD_Out, Mem_WR_Out, Mem_Address_Out, Mem_Data_Out
  );

  modport slave (
    input  MemCtrl_RD_In, MemCtrl_WR_In, MemCtrl_Address_In, MemCtrl_Data_In, Mem_Data_In,
    output MemCtrl_Data_Out, MemCtrl_ACK_Out, MemCtrl_Busy_Out, MemCtrl_Error_Out,
    output Mem_RD_Out, Mem_WR_Out, Mem_Address_Out, Mem_Data_Out
  );
endinterface

`default_nettype wire

// File: rtl/memctrl_wait_counter.sv
// ============================================================================
// Module : memctrl_wait_counter
// Brief  : Loadable wait-state down-counter with zero flag; never underflows.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module memctrl_wait_counter #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             decrement,
  input  wire logic [WIDTH-1:0] loadValue,
  output logic                  isZero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= loadValue;
    end else if (decrement && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign isZero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/data_memory_ctrl.sv
// ============================================================================
// Module : data_memory_ctrl
// Brief  : Multi-cycle data-memory access controller with wait states and ACK.
//          Optional alignment check enabled by defining MEMCTRL_ALIGN_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_memory_ctrl
  import data_memory_ctrl_pkg::*;
#(
  parameter int DATAWIDTH_BUS      = 32,
  parameter int WAIT_STATES        = c_DEFAULT_WAIT_STATES,
  parameter int DATAWIDTH_WAIT_CNT = 4
) (
  input  wire logic          MemCtrl_CLOCK_50,
  input  wire logic          MemCtrl_RESET_InHigh,
  data_memory_ctrl_if.slave  bus
);

  localparam logic [DATAWIDTH_WAIT_CNT-1:0] c_LOAD_VALUE =
    DATAWIDTH_WAIT_CNT'(satLoad(WAIT_STATES, DATAWIDTH_WAIT_CNT));

  logic [1:0]               r_state;
  logic                     r_op;
  logic [DATAWIDTH_BUS-1:0] r_addr;
  logic [DATAWIDTH_BUS-1:0] r_wrData;
  logic [DATAWIDTH_BUS-1:0] r_rdData;
  logic                     w_request;
  logic                     w_cntLoad;
  logic                     w_cntDec;
  logic                     w_cntZero;

  assign w_request = bus.MemCtrl_RD_In | bus.MemCtrl_WR_In;
  assign w_cntLoad = (r_state == c_IDLE) && w_request;
  assign w_cntDec  = (r_state == c_ACCESS) && !w_cntZero;

  memctrl_wait_counter #(
    .WIDTH (DATAWIDTH_WAIT_CNT)
  ) u_waitCounter (
    .clk       (MemCtrl_CLOCK_50),
    .rst       (MemCtrl_RESET_InHigh),
    .load      (w_cntLoad),
    .decrement (w_cntDec),
    .loadValue (c_LOAD_VALUE),
    .isZero    (w_cntZero)
  );

`ifdef MEMCTRL_ALIGN_CHECK_EN
  logic r_err;
  logic w_misaligned;
  assign w_misaligned = (bus.MemCtrl_Address_In[1:0] != 2'b00);
`endif

  always_ff @(posedge MemCtrl_CLOCK_50 or posedge MemCtrl_RESET_InHigh) begin
    if (MemCtrl_RESET_InHigh) begin
      r_state  <= c_IDLE;
      r_op     <= c_OP_WR;
      r_addr   <= '0;
      r_wrData <= '0;
      r_rdData <= '0;
`ifdef MEMCTRL_ALIGN_CHECK_EN
      r_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_request) begin
            r_addr   <= bus.MemCtrl_Address_In;
            r_wrData <= bus.MemCtrl_Data_In;
            r_op     <= bus.MemCtrl_RD_In ? c_OP_RD : c_OP_WR;
`ifdef MEMCTRL_ALIGN_CHECK_EN
            r_err    <= w_misaligned;
            r_state  <= w_misaligned ? c_ACKNOWLEDGE : c_ACCESS;
`else
            r_state  <= c_ACCESS;
`endif
          end
        end
        c_ACCESS: begin
          if (w_cntZero) begin
            if (r_op == c_OP_RD) r_rdData <= bus.Mem_Data_In;
            r_state <= c_ACKNOWLEDGE;
          end
        end
        c_ACKNOWLEDGE: r_state <= c_RELEASE;
        // A held request must be released before another access can start.
        c_RELEASE: if (!w_request) r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Outputs decode from state so an asynchronous reset drops strobes at once.
  assign bus.Mem_RD_Out       = (r_state == c_ACCESS) && (r_op == c_OP_RD);
  assign bus.Mem_WR_Out       = (r_state == c_ACCESS) && (r_op == c_OP_WR);
  assign bus.Mem_Address_Out  = r_addr;
  assign bus.Mem_Data_Out     = r_wrData;
  assign bus.MemCtrl_Data_Out = r_rdData;
  assign bus.MemCtrl_ACK_Out  = (r_state == c_ACKNOWLEDGE);
  assign bus.MemCtrl_Busy_Out = (r_state != c_IDLE);
`ifdef MEMCTRL_ALIGN_CHECK_EN
  assign bus.MemCtrl_Error_Out = (r_state == c_ACKNOWLEDGE) && r_err;
`else
  assign bus.MemCtrl_Error_Out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
// ============================================================================
// Module : tb_data_memory_ctrl
// Brief  : Self-checking bench: vector table, hand sequences, random vs model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_memory_ctrl;

  localparam int WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  data_memory_ctrl_if #(.DATAWIDTH_BUS(32)) bus ();

  data_memory_ctrl #(
    .DATAWIDTH_BUS      (32),
    .WAIT_STATES        (WAIT),
    .DATAWIDTH_WAIT_CNT (4)
  ) dut (
    .MemCtrl_CLOCK_50     (clk),
    .MemCtrl_RESET_InHigh (rst),
    .bus                  (bus.slave)
  );

  // Data_Memory stand-in: combinational read, write on strobe.
  logic [31:0] memArr [0:255] = '{default: 32'h0};
  assign bus.Mem_Data_In = memArr[bus.Mem_Address_Out[9:2]];
  always @(posedge clk) if (bus.Mem_WR_Out) memArr[bus.Mem_Address_Out[9:2]] <= bus.Mem_Data_Out;

  // Reference model: word-addressed memory and the last value read.
  logic [31:0] refMem [int];
  logic [31:0] refDataOut;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
    logic [31:0] expData;
    int          expAck;
    int          expRdCnt;
    int          expWrCnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input logic [31:0] addr);
    int key;
    key = int'(addr[9:2]);
    return refMem.exists(key) ? refMem[key] : 32'h0;
  endfunction

  function automatic logic isMisaligned(input logic [31:0] addr);
`ifdef MEMCTRL_ALIGN_CHECK_EN
    return addr[1:0] != 2'b00;
`else
    return (addr[1:0] != 2'b00) && 1'b0;
`endif
  endfunction

  // Drives one request from a negedge and observes it until the controller idles.
  task automatic runAccess(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input int hold, input int dropAfter,
                           output int ackAt, output int rdCnt, output int wrCnt,
                           output int ackCnt, output int endAt, output logic [31:0] dOut,
                           output logic err, output logic timedOut);
    bit dropped;
    dropped = 0;
    ackAt = 0; rdCnt = 0; wrCnt = 0; ackCnt = 0; endAt = 0;
    dOut = 32'h0; err = 1'b0; timedOut = 1'b1;
    bus.MemCtrl_RD_In      = rd;
    bus.MemCtrl_WR_In      = wr;
    bus.MemCtrl_Address_In = addr;
    bus.MemCtrl_Data_In    = data;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus.Mem_RD_Out) rdCnt++;
      if (bus.Mem_WR_Out) wrCnt++;
      if (bus.MemCtrl_ACK_Out) begin
        ackCnt++;
        if (ackCnt == 1) begin
          ackAt = n;
          dOut  = bus.MemCtrl_Data_Out;
          err   = bus.MemCtrl_Error_Out;
        end
      end
      if (!dropped && ((dropAfter > 0 && n >= dropAfter) || (ackCnt > 0 && n >= ackAt + hold))) begin
        bus.MemCtrl_RD_In = 1'b0;
        bus.MemCtrl_WR_In = 1'b0;
        dropped = 1;
      end
      if (dropped && ackCnt > 0 && !bus.MemCtrl_Busy_Out) begin
        endAt = n;
        timedOut = 1'b0;
        break;
      end
    end
    bus.MemCtrl_RD_In = 1'b0;
    bus.MemCtrl_WR_In = 1'b0;
    @(negedge clk);
  endtask

  // Runs a transaction and checks every observable against the reference model.
  task automatic modelTxn(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input int hold, input int dropAfter);
    int ackAt, rdCnt, wrCnt, ackCnt, endAt, relHold;
    logic [31:0] dOut;
    logic err, tmo, mis, isRead;
    logic [31:0] expData;
    mis     = isMisaligned(addr);
    isRead  = rd;
    expData = (mis || !isRead) ? refDataOut : refLoad(addr);
    runAccess(rd, wr, addr, data, hold, dropAfter, ackAt, rdCnt, wrCnt, ackCnt, endAt, dOut, err, tmo);
    relHold = (dropAfter > 0) ? 0 : hold;
    check({tag, "_timeout"}, 32'(tmo), 32'd0);
    check({tag, "_ackAt"},   32'(ackAt), mis ? 32'd1 : 32'(WAIT + 2));
    check({tag, "_rdCnt"},   32'(rdCnt), (!mis && isRead)  ? 32'(WAIT + 1) : 32'd0);
    check({tag, "_wrCnt"},   32'(wrCnt), (!mis && !isRead) ? 32'(WAIT + 1) : 32'd0);
    check({tag, "_ackCnt"},  32'(ackCnt), 32'd1);
    check({tag, "_data"},    dOut, expData);
    check({tag, "_err"},     32'(err), 32'(mis));
    check({tag, "_endAt"},   32'(endAt), 32'(ackAt + ((relHold + 1 > 2) ? relHold + 1 : 2)));
    if (!mis && !isRead) refMem[int'(addr[9:2])] = data;
    if (isRead) refDataOut = expData;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ackAt, rdCnt, wrCnt, ackCnt, endAt;
    logic [31:0] dOut;
    logic err, tmo;

    vecs[0] = '{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h00000000, WAIT + 2, 0, WAIT + 1};
    vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h0,        5, 32'hDEADBEEF, WAIT + 2, WAIT + 1, 0};
    vecs[2] = '{1'b0, 1'b1, 32'h20, 32'h12345678, 1, 32'hDEADBEEF, WAIT + 2, 0, WAIT + 1};
    vecs[3] = '{1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 0, 32'h12345678, WAIT + 2, WAIT + 1, 0};
    vecs[4] = '{1'b1, 1'b0, 32'h10, 32'h0,        2, 32'hDEADBEEF, WAIT + 2, WAIT + 1, 0};
    vecs[5] = '{1'b0, 1'b1, 32'h24, 32'h0BADF00D, 3, 32'hDEADBEEF, WAIT + 2, 0, WAIT + 1};

    // Reset held with a read request pending.
    bus.MemCtrl_RD_In      = 1'b1;
    bus.MemCtrl_WR_In      = 1'b0;
    bus.MemCtrl_Address_In = 32'h8;
    bus.MemCtrl_Data_In    = 32'h55;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {bus.Mem_RD_Out, bus.Mem_WR_Out, bus.MemCtrl_ACK_Out,
                          bus.MemCtrl_Busy_Out, bus.MemCtrl_Error_Out}, 32'h0);
    check("rst_dataOut", bus.MemCtrl_Data_Out, 32'h0);
    check("rst_memAddr", bus.Mem_Address_Out, 32'h0);
    check("rst_memData", bus.Mem_Data_Out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    refDataOut = 32'h0;
    runAccess(1'b1, 1'b0, 32'h8, 32'h55, 0, 0, ackAt, rdCnt, wrCnt, ackCnt, endAt, dOut, err, tmo);
    check("rst_release_ackAt", 32'(ackAt), 32'(WAIT + 2));
    check("rst_release_rdCnt", 32'(rdCnt), 32'(WAIT + 1));

    for (int i = 0; i < 6; i++) begin
      runAccess(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].hold, 0,
                ackAt, rdCnt, wrCnt, ackCnt, endAt, dOut, err, tmo);
      check($sformatf("vec%0d_ackAt", i), 32'(ackAt), 32'(vecs[i].expAck));
      check($sformatf("vec%0d_rdCnt", i), 32'(rdCnt), 32'(vecs[i].expRdCnt));
      check($sformatf("vec%0d_wrCnt", i), 32'(wrCnt), 32'(vecs[i].expWrCnt));
      check($sformatf("vec%0d_ackCnt", i), 32'(ackCnt), 32'd1);
      check($sformatf("vec%0d_data", i), dOut, vecs[i].expData);
      if (vecs[i].rd) refDataOut = vecs[i].expData;
      else refMem[int'(vecs[i].addr[9:2])] = vecs[i].data;
    end

    // Request dropped right after it was taken: access still completes.
    modelTxn("drop_rd", 1'b1, 1'b0, 32'h20, 32'h0, 0, 1);
    modelTxn("drop_wr", 1'b0, 1'b1, 32'h28, 32'hCAFEF00D, 0, 1);
    modelTxn("readback", 1'b1, 1'b0, 32'h28, 32'h0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      logic        rRd, rWr;
      logic [31:0] rAddr, rData;
      int          sel;
      sel   = int'($urandom_range(0, 2));
      rRd   = (sel != 1);
      rWr   = (sel != 0);
      rAddr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      rData = $urandom;
      modelTxn($sformatf("rnd%0d", t), rRd, rWr, rAddr, rData, int'($urandom_range(0, 3)), 0);
    end

    // Reset during the second ACCESS cycle of a write.
    bus.MemCtrl_WR_In      = 1'b1;
    bus.MemCtrl_Address_In = 32'h80;
    bus.MemCtrl_Data_In    = 32'hA5A5A5A5;
    @(posedge clk); #1;
    check("rstmid_wr_c1", 32'(bus.Mem_WR_Out), 32'd1);
    @(posedge clk); #1;
    check("rstmid_wr_c2", 32'(bus.Mem_WR_Out), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("rstmid_wr_drop", 32'(bus.Mem_WR_Out), 32'd0);
    check("rstmid_busy", 32'(bus.MemCtrl_Busy_Out), 32'd0);
    bus.MemCtrl_WR_In = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    refDataOut = 32'h0;
    ackCnt = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (bus.MemCtrl_ACK_Out) ackCnt++;
    end
    check("rstmid_noAck", 32'(ackCnt), 32'd0);
    check("rstmid_dataOut", bus.MemCtrl_Data_Out, 32'h0);
    @(negedge clk);

    // Misaligned read: error path when the check is built in, plain read otherwise.
    modelTxn("misalign", 1'b1, 1'b0, 32'h13, 32'h0, 0, 0);
`ifdef MEMCTRL_ALIGN_CHECK_EN
    runAccess(1'b1, 1'b0, 32'h13, 32'h0, 0, 0, ackAt, rdCnt, wrCnt, ackCnt, endAt, dOut, err, tmo);
    check("align_ackAt", 32'(ackAt), 32'd1);
    check("align_err", 32'(err), 32'd1);
    check("align_noStrobe", 32'(rdCnt + wrCnt), 32'd0);
    check("align_data", dOut, refDataOut);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

`default_nettype wire
